// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared state type and reset values for the alarm clock display/alarm controller
package aclk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  localparam logic RST_MATCH_Q  = 1'b1;
  localparam logic RST_SOUND_A  = 1'b0;
  localparam logic RST_SNOOZING = 1'b0;

endpackage

// File: rtl/aclk_digit_mux.sv
// rtl/aclk_digit_mux.sv - one registered display digit: alarm over key over current time
module aclk_digit_mux #(
  parameter int DIGIT_W = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_show_a,
  input  logic               i_show_key,
  input  logic [DIGIT_W-1:0] i_alarm,
  input  logic [DIGIT_W-1:0] i_key,
  input  logic [DIGIT_W-1:0] i_current,
  output logic [DIGIT_W-1:0] o_digit
);

  logic [DIGIT_W-1:0] r_digit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_digit <= '0;
    end else if (i_show_a) begin
      r_digit <= i_alarm;
    end else if (i_show_key) begin
      r_digit <= i_key;
    end else begin
      r_digit <= i_current;
    end
  end

  assign o_digit = r_digit;

endmodule

// File: rtl/aclk_lcd_driver_n.sv
// rtl/aclk_lcd_driver_n.sv - N-digit display select plus alarm ring/snooze/stop controller
import aclk_pkg::*;

module aclk_lcd_driver_n #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_one_second,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_alarm_time,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_current_time,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_key,
  input  logic                          i_show_a,
  input  logic                          i_show_current_time,
  input  logic                          i_alarm_enable,
  input  logic                          i_stop_alarm,
  input  logic                          i_snooze,
  output logic [NUM_DIGITS*DIGIT_W-1:0] o_display_time,
  output logic                          o_sound_a,
  output logic                          o_snoozing
);

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  localparam int NW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      aclk_digit_mux #(.DIGIT_W(DIGIT_W)) u_mux (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_show_a   (i_show_a),
        .i_show_key (i_show_current_time),
        .i_alarm    (i_alarm_time[g*DIGIT_W +: DIGIT_W]),
        .i_key      (i_key[g*DIGIT_W +: DIGIT_W]),
        .i_current  (i_current_time[g*DIGIT_W +: DIGIT_W]),
        .o_digit    (o_display_time[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  alarm_state_t  r_state;
  logic [RW-1:0] r_ring_cnt;
  logic [SW-1:0] r_snz_cnt;
  logic [NW-1:0] r_snz_num;
  logic          r_match_q;
  logic          r_sound_a;
  logic          r_snoozing;
  logic          w_match;
  logic          w_start;

  assign w_match = i_alarm_enable && (i_alarm_time == i_current_time);
  assign w_start = w_match && !r_match_q;

  // Outputs are loaded together with the state they belong to, so they track next-state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_snz_num  <= '0;
      r_match_q  <= RST_MATCH_Q;
      r_sound_a  <= RST_SOUND_A;
      r_snoozing <= RST_SNOOZING;
    end else begin
      r_match_q <= w_match;
      if (!i_alarm_enable) begin
        r_state    <= IDLE;
        r_sound_a  <= 1'b0;
        r_snoozing <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_state    <= RING;
              r_ring_cnt <= '0;
              r_snz_num  <= '0;
              r_sound_a  <= 1'b1;
            end
          end
          RING: begin
            if (i_stop_alarm) begin
              r_state   <= IDLE;
              r_sound_a <= 1'b0;
            end else if (i_snooze && (32'(r_snz_num) < MAX_SNOOZE)) begin
              r_state    <= SNOOZE;
              r_snz_cnt  <= '0;
              r_snz_num  <= r_snz_num + NW'(1);
              r_sound_a  <= 1'b0;
              r_snoozing <= 1'b1;
            end else if (i_one_second) begin
              if (r_ring_cnt == RW'(RING_SECS - 1)) begin
                r_state   <= IDLE;
                r_sound_a <= 1'b0;
              end else begin
                r_ring_cnt <= r_ring_cnt + RW'(1);
              end
            end
          end
          SNOOZE: begin
            if (i_stop_alarm) begin
              r_state    <= IDLE;
              r_snoozing <= 1'b0;
            end else if (i_one_second) begin
              if (r_snz_cnt == SW'(SNOOZE_SECS - 1)) begin
                r_state    <= RING;
                r_ring_cnt <= '0;
                r_sound_a  <= 1'b1;
                r_snoozing <= 1'b0;
              end else begin
                r_snz_cnt <= r_snz_cnt + SW'(1);
              end
            end
          end
          default: begin
            r_state    <= IDLE;
            r_sound_a  <= 1'b0;
            r_snoozing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sound_a  = r_sound_a;
  assign o_snoozing = r_snoozing;

endmodule

// File: tb/tb_aclk_lcd_driver_n.sv
// tb/tb_aclk_lcd_driver_n.sv - directed and randomized checks of aclk_lcd_driver_n against a behavioural model
module tb_aclk_lcd_driver_n;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int W  = ND * DW;
  localparam int RS = 60;
  localparam int SS = 300;
  localparam int MS = 3;

  logic         clk = 1'b0;
  logic         reset, tick, en, stop, snz, show_a, show_k;
  logic [W-1:0] alarm, cur, key;
  logic [W-1:0] disp;
  logic         sound, snoozing;

  always #5 clk = ~clk;

  aclk_lcd_driver_n #(
    .NUM_DIGITS(ND), .DIGIT_W(DW), .RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MS)
  ) dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_one_second        (tick),
    .i_alarm_time        (alarm),
    .i_current_time      (cur),
    .i_key               (key),
    .i_show_a            (show_a),
    .i_show_current_time (show_k),
    .i_alarm_enable      (en),
    .i_stop_alarm        (stop),
    .i_snooze            (snz),
    .o_display_time      (disp),
    .o_sound_a           (sound),
    .o_snoozing          (snoozing)
  );

  // Model: mode 0 quiet, 1 ringing, 2 snoozing; seconds left count down to zero.
  int           m_mode = 0;
  int           ring_left = 0;
  int           snz_left = 0;
  int           snz_used = 0;
  bit           prev_match = 1'b1;
  logic [W-1:0] e_disp = '0;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic cyc();
    bit match, rise;
    match = en && (alarm == cur);
    rise  = match && !prev_match;
    prev_match = match;
    if (reset) begin
      m_mode = 0; ring_left = 0; snz_left = 0; snz_used = 0;
      prev_match = 1'b1;
      e_disp = '0;
    end else begin
      e_disp = show_a ? alarm : (show_k ? key : cur);
      if (!en) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (rise) begin m_mode = 1; ring_left = RS; snz_used = 0; end
      end else if (m_mode == 1) begin
        if (stop) m_mode = 0;
        else if (snz && snz_used < MS) begin m_mode = 2; snz_left = SS; snz_used++; end
        else if (tick) begin ring_left--; if (ring_left == 0) m_mode = 0; end
      end else begin
        if (stop) m_mode = 0;
        else if (tick) begin snz_left--; if (snz_left == 0) begin m_mode = 1; ring_left = RS; end end
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    assert (disp === e_disp) else begin
      miscompares++;
      $error("FAIL display observed=%h expected=%h at %0t", disp, e_disp, $time);
    end
    assert (sound === (m_mode == 1)) else begin
      miscompares++;
      $error("FAIL sound_a observed=%b expected=%b at %0t", sound, (m_mode == 1), $time);
    end
    assert (snoozing === (m_mode == 2)) else begin
      miscompares++;
      $error("FAIL snoozing observed=%b expected=%b at %0t", snoozing, (m_mode == 2), $time);
    end
  endtask

  // tm: 0 no ticks, 1 tick every cycle, 2 random ticks; display selects and key randomized
  task automatic run(input int n, input int tm);
    for (int i = 0; i < n; i++) begin
      tick   = (tm == 1) ? 1'b1 : (tm == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      show_a = 1'($urandom_range(0, 1));
      show_k = 1'($urandom_range(0, 1));
      key    = W'($urandom);
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic trigger();
    cur = 16'h0711;
    run(2, 0);
    cur = 16'h0712;
    run(2, 0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; en = 1'b1; stop = 1'b0; snz = 1'b0;
    show_a = 1'b0; show_k = 1'b0;
    alarm = 16'h0712; cur = 16'h0712; key = '0;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    run(100, 2);

    // Step into the alarm minute, ring out the full duration
    trigger();
    run(RS + 10, 1);

    // Three snoozes honoured, the fourth ignored
    trigger();
    for (int k = 0; k < 4; k++) begin
      snz = 1'b1; run(1, 0); snz = 1'b0;
      run(5, 2);
      if (k < 3) run(SS + 5, 1);
    end
    run(RS + 5, 1);

    // Stop and snooze together while ringing
    trigger();
    stop = 1'b1; snz = 1'b1; run(2, 0);
    stop = 1'b0; snz = 1'b0; run(3, 0);

    // Directed display priority
    show_a = 1'b1; show_k = 1'b1; alarm = 16'h1230; key = 16'h0945; cyc();
    show_a = 1'b0; cyc();
    alarm = 16'h0712;
    run(3, 0);

    // Disable mid-ring, then re-enable while times match
    trigger();
    run(4, 1);
    en = 1'b0; run(2, 0);
    en = 1'b1; run(4, 2);
    stop = 1'b1; run(1, 0); stop = 1'b0;

    // Reset mid-ring must not re-fire while times stay equal
    trigger();
    run(5, 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    run(10, 1);

    // Randomized mix of match edges, ticks and controls
    for (int i = 0; i < 600; i++) begin
      cur  = ($urandom_range(0, 3) == 0) ? 16'h0711 : 16'h0712;
      en   = ($urandom_range(0, 19) != 0);
      stop = ($urandom_range(0, 39) == 0);
      snz  = ($urandom_range(0, 9) == 0);
      run(1, 2);
    end
    stop = 1'b0; snz = 1'b0; en = 1'b1;
    run(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
